// File: rtl/pong_rally_ctrl.sv
// ---------------------------------------------------------------------------
// pong_rally_ctrl
// Pong game controller for an N-position one-hot LED field. Ball movement,
// paddle checks and serves advance only on clk edges where `tick` is high.
// Each player has a score counter that runs to WIN_SCORE, after which the
// game sits in GAME_OVER until a serve starts a new game. The player who
// loses a point serves the next ball.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   tick       in   game-rate enable
//   serve      in   serve / new-game request (sampled on tick)
//   paddle1    in   player-1 paddle (field MSB end)
//   paddle2    in   player-2 paddle (field LSB end)
//   field      out  [FIELD_W]  one-hot ball, zero when idle, all ones at game over
//   p1_score   out  [SCORE_W]  player-1 points
//   p2_score   out  [SCORE_W]  player-2 points
//   p1_point   out  one-clk pulse when player 1 scores
//   p2_point   out  one-clk pulse when player 2 scores
//   game_over  out  high while in GAME_OVER
//   winner     out  0 = player 1 won, 1 = player 2 won (valid with game_over)
//
// Optional build macro: PONG_SPEEDUP_EN
//   When defined, each rally starts with the ball stepping on every second
//   tick, switching to every tick after SPEEDUP_HITS returns in that rally.
// ---------------------------------------------------------------------------
module pong_rally_ctrl #(
  parameter int FIELD_W      = 8,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SPEEDUP_HITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               serve,
  input  logic               paddle1,
  input  logic               paddle2,
  output logic [FIELD_W-1:0] field,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               p1_point,
  output logic               p2_point,
  output logic               game_over,
  output logic               winner
);

  localparam int PW = $clog2(FIELD_W);

  localparam logic [PW-1:0]      POS_ONE = PW'(1);
  localparam logic [PW-1:0]      POS_MID = PW'(FIELD_W / 2);
  localparam logic [PW-1:0]      POS_MAX = PW'(FIELD_W - 1);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);

  // Reject illegal parameter sets at elaboration
  if (FIELD_W < 3 || FIELD_W > 32 || WIN_SCORE < 1 ||
      WIN_SCORE > (2 ** SCORE_W) - 1 || SPEEDUP_HITS < 1) begin : g_param_check
    $error("pong_rally_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RALLY = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic          dir;     // 1: moving toward P2 (pos decrements)
  logic          server;  // 0: P1 serves, 1: P2 serves

  logic               step_s;
  logic               at_end_s;
  logic               recv_paddle_s;
  logic               act_s;
  logic               hit_s;
  logic               miss_s;
  logic               launch_s;
  logic               newgame_s;
  logic [PW-1:0]      pos_next_s;
  logic [PW-1:0]      bounce_pos_s;
  logic [SCORE_W-1:0] p1_inc_s;
  logic [SCORE_W-1:0] p2_inc_s;

  function automatic logic [FIELD_W-1:0] onehot(input logic [PW-1:0] p);
    logic [FIELD_W-1:0] v;
    v    = {FIELD_W{1'b0}};
    v[p] = 1'b1;
    return v;
  endfunction

`ifdef PONG_SPEEDUP_EN
  localparam int HW = $clog2(SPEEDUP_HITS + 1);

  logic [HW-1:0] hits;
  logic          phase;   // slow mode: the ball acts when this is set
  logic          fast_s;

  assign fast_s = (hits >= HW'(SPEEDUP_HITS));
  assign step_s = fast_s | phase;
`else
  assign step_s = 1'b1;
`endif

  // Rally event decode: end-of-field detection, paddle selection, next position
  always_comb begin
    at_end_s      = (state == ST_RALLY) &&
                    ((dir && (pos == {PW{1'b0}})) || (!dir && (pos == POS_MAX)));
    // Only the receiver's paddle counts; the other one is ignored
    recv_paddle_s = dir ? paddle2 : paddle1;
    act_s         = tick && (state == ST_RALLY) && step_s;
    hit_s         = act_s && at_end_s && recv_paddle_s;
    miss_s        = act_s && at_end_s && !recv_paddle_s;
    launch_s      = tick && serve && (state == ST_IDLE);
    newgame_s     = tick && serve && (state == ST_OVER);
    pos_next_s    = dir ? (pos - POS_ONE) : (pos + POS_ONE);
    // After a hit the ball leaves the end it was sitting on
    bounce_pos_s  = dir ? POS_ONE : (POS_MAX - POS_ONE);
    p1_inc_s      = p1_score + SCORE_W'(1);
    p2_inc_s      = p2_score + SCORE_W'(1);
  end

`ifdef PONG_SPEEDUP_EN
  // Speed state: phase toggles every rally tick while slow, hits count returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits  <= {HW{1'b0}};
      phase <= 1'b0;
    end else if (launch_s || newgame_s || miss_s) begin
      hits  <= {HW{1'b0}};
      phase <= 1'b0;
    end else begin
      if (tick && (state == ST_RALLY) && !fast_s) begin
        phase <= ~phase;
      end else begin
        phase <= phase;
      end
      if (hit_s && !fast_s) begin
        hits <= hits + HW'(1);
      end else begin
        hits <= hits;
      end
    end
  end
`endif

  // Game FSM: ball motion, scoring, serve ownership and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pos       <= {PW{1'b0}};
      dir       <= 1'b0;
      server    <= 1'b0;
      field     <= {FIELD_W{1'b0}};
      p1_score  <= {SCORE_W{1'b0}};
      p2_score  <= {SCORE_W{1'b0}};
      p1_point  <= 1'b0;
      p2_point  <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      // Point pulses last one clk regardless of tick
      p1_point <= 1'b0;
      p2_point <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (serve) begin
              pos   <= POS_MID;
              dir   <= ~server;  // P1 serves toward P2 and vice versa
              field <= onehot(POS_MID);
              state <= ST_RALLY;
            end else begin
              field <= {FIELD_W{1'b0}};
            end
          end
          ST_RALLY: begin
            if (step_s) begin
              if (at_end_s) begin
                if (recv_paddle_s) begin
                  dir   <= ~dir;
                  pos   <= bounce_pos_s;
                  field <= onehot(bounce_pos_s);
                end else if (dir) begin
                  // P2 missed: point to P1, P2 serves next
                  p1_score <= p1_inc_s;
                  p1_point <= 1'b1;
                  server   <= 1'b1;
                  if (p1_inc_s == WIN_S) begin
                    state     <= ST_OVER;
                    game_over <= 1'b1;
                    winner    <= 1'b0;
                    field     <= {FIELD_W{1'b1}};
                  end else begin
                    state <= ST_IDLE;
                    field <= {FIELD_W{1'b0}};
                  end
                end else begin
                  // P1 missed: point to P2, P1 serves next
                  p2_score <= p2_inc_s;
                  p2_point <= 1'b1;
                  server   <= 1'b0;
                  if (p2_inc_s == WIN_S) begin
                    state     <= ST_OVER;
                    game_over <= 1'b1;
                    winner    <= 1'b1;
                    field     <= {FIELD_W{1'b1}};
                  end else begin
                    state <= ST_IDLE;
                    field <= {FIELD_W{1'b0}};
                  end
                end
              end else begin
                pos   <= pos_next_s;
                field <= onehot(pos_next_s);
              end
            end else begin
              field <= onehot(pos);
            end
          end
          ST_OVER: begin
            if (serve) begin
              // New game only; the ball is launched by a later serve
              p1_score  <= {SCORE_W{1'b0}};
              p2_score  <= {SCORE_W{1'b0}};
              game_over <= 1'b0;
              server    <= 1'b0;
              field     <= {FIELD_W{1'b0}};
              state     <= ST_IDLE;
            end else begin
              field <= {FIELD_W{1'b1}};
            end
          end
          default: begin
            state <= ST_IDLE;
            field <= {FIELD_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_rally_ctrl.sv
module tb_pong_rally_ctrl;

  localparam int FIELD_W = 8;
  localparam int SCORE_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic               serve = 1'b0;
  logic               paddle1 = 1'b0;
  logic               paddle2 = 1'b0;
  logic [FIELD_W-1:0] field;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               p1_point;
  logic               p2_point;
  logic               game_over;
  logic               winner;

  pong_rally_ctrl #(
    .FIELD_W(FIELD_W), .SCORE_W(SCORE_W), .WIN_SCORE(3), .SPEEDUP_HITS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .serve(serve),
    .paddle1(paddle1), .paddle2(paddle2), .field(field),
    .p1_score(p1_score), .p2_score(p2_score),
    .p1_point(p1_point), .p2_point(p2_point),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               tick, serve, p1, p2;
    logic [FIELD_W-1:0] field;
    logic [SCORE_W-1:0] s1, s2;
    logic               pt1, pt2, go, win;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic t, input logic s, input logic a, input logic b,
                     input logic [FIELD_W-1:0] f, input logic [SCORE_W-1:0] s1,
                     input logic [SCORE_W-1:0] s2, input logic pt1, input logic pt2,
                     input logic go, input logic win);
    vec_t v;
    v.tick = t; v.serve = s; v.p1 = a; v.p2 = b; v.field = f;
    v.s1 = s1; v.s2 = s2; v.pt1 = pt1; v.pt2 = pt2; v.go = go; v.win = win;
    vecs.push_back(v);
  endtask

  task automatic check_all(input vec_t e);
    chk("field", 32'(field), 32'(e.field));
    chk("p1_score", 32'(p1_score), 32'(e.s1));
    chk("p2_score", 32'(p2_score), 32'(e.s2));
    chk("p1_point", 32'(p1_point), 32'(e.pt1));
    chk("p2_point", 32'(p2_point), 32'(e.pt2));
    chk("game_over", 32'(game_over), 32'(e.go));
    if (e.go) chk("winner", 32'(winner), 32'(e.win));
  endtask

  // Drive each row before a rising edge, compare its expectation just after
  task automatic run_table();
    vec_t e;
    foreach (vecs[i]) begin
      @(negedge clk);
      tick = vecs[i].tick; serve = vecs[i].serve;
      paddle1 = vecs[i].p1; paddle2 = vecs[i].p2;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      row = i;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard: queue empty at row %0d", i);
      end else begin
        e = exp_q.pop_front();
        check_all(e);
      end
    end
    @(negedge clk);
    tick = 1'b0; serve = 1'b0; paddle1 = 1'b0; paddle2 = 1'b0;
    vecs.delete();
  endtask

  // P2 serves, P1 returns once, P2 misses: P1 gains a point
  task automatic p1_point_rally(input logic [SCORE_W-1:0] s1_after, input logic over);
    logic [FIELD_W-1:0] f;
    add(1, 1, 0, 0, 8'h10, s1_after - 4'd1, 0, 0, 0, 0, 0);
    for (int i = 5; i <= 7; i++) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, s1_after - 4'd1, 0, 0, 0, 0, 0);
    end
    add(1, 0, 1, 0, 8'h40, s1_after - 4'd1, 0, 0, 0, 0, 0);
    for (int i = 5; i >= 0; i--) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, s1_after - 4'd1, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, over ? 8'hFF : 8'h00, s1_after, 0, 1, 0, over, 0);
  endtask

  initial begin
    logic [FIELD_W-1:0] f;

    // Reset state while rst is held
    #12;
    row = -1;
    chk("rst_field", 32'(field), 32'h0);
    chk("rst_p1_score", 32'(p1_score), 32'h0);
    chk("rst_p2_score", 32'(p2_score), 32'h0);
    chk("rst_game_over", 32'(game_over), 32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifndef PONG_SPEEDUP_EN
    // P1 serve toward P2, P2 misses
    add(1, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      f = 8'h10 >> i;
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 8'h00, 1, 0, 0, 0, 0, 0);
    // P2 serves toward P1; P1 hits
    add(1, 1, 0, 0, 8'h10, 1, 0, 0, 0, 0, 0);
    for (int i = 5; i <= 7; i++) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, 1, 0, 0, 0, 0, 0);
    end
    add(1, 0, 1, 0, 8'h40, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h20, 1, 0, 0, 0, 0, 0);
    // tick low with paddles toggling: everything holds
    for (int k = 0; k < 20; k++) add(0, k[0], k[0], ~k[0], 8'h20, 1, 0, 0, 0, 0, 0);
    // Paddles at a non-end position are ignored
    add(1, 0, 1, 1, 8'h10, 1, 0, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, 1, 0, 0, 0, 0, 0);
    end
    // Both paddles high at the P2 end: P2 return
    add(1, 0, 1, 1, 8'h02, 1, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 7; i++) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, 1, 0, 0, 0, 0, 0);
    end
    // P1 misses although paddle2 is high
    add(1, 0, 0, 1, 8'h00, 1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    run_table();
`else
    // Slow rally: one step per two ticks, paddle ignored on non-step ticks
    add(1, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      f = 8'h10 >> (i - 1);
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
      f = 8'h10 >> i;
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 8'h02, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 7; i++) begin
      f = 8'h01 << (i - 1);
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    // Second return: now every tick
    for (int i = 5; i >= 0; i--) begin
      f = 8'h01 << i;
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    // Next rally starts slow again
    add(1, 1, 0, 0, 8'h10, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h10, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h20, 1, 0, 0, 0, 0, 0);
    run_table();
`endif

    // Asynchronous reset between clock edges, mid-rally
    tick = 1'b1; serve = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    serve = 1'b0;
    @(posedge clk); #1;
    row = -2;
    chk("pre_rst_field_nonzero", 32'(field != 8'h00), 32'h1);
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_field", 32'(field), 32'h0);
    chk("async_rst_p1_score", 32'(p1_score), 32'h0);
    chk("async_rst_p2_score", 32'(p2_score), 32'h0);
    chk("async_rst_p1_point", 32'(p1_point), 32'h0);
    chk("async_rst_p2_point", 32'(p2_point), 32'h0);
    @(negedge clk);
    rst = 1'b0;

`ifndef PONG_SPEEDUP_EN
    // Three P1 points to game over, then restart
    add(1, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      f = 8'h10 >> i;
      add(1, 0, 0, 0, f, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
    p1_point_rally(4'd2, 1'b0);
    p1_point_rally(4'd3, 1'b1);
    add(1, 0, 1, 1, 8'hFF, 3, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 8'hFF, 3, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    // Server back to P1 after a new game
    add(1, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h08, 0, 0, 0, 0, 0, 0);
    run_table();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_rally_ctrl.md
Name: pong_rally_ctrl

Overview:
Parametrised pong-game controller that generalises the fixed 5-LED game state machine to an N-position one-hot field. Ball position, direction and rally flow advance only on `tick`, the slow game-rate enable from the existing tick/clock-divider path. Per-player score counters run to a programmable win target, followed by a game-over state. Serve alternates to the loser of each point. Outputs drive the LED field and the score display logic directly.

Parameters:
FIELD_W, 8, number of field positions / LEDs; legal range 3..32.
SCORE_W, 4, width of each score counter.
WIN_SCORE, 7, points needed to win; must satisfy 1 <= WIN_SCORE <= 2^SCORE_W-1.
SPEEDUP_HITS, 4, returns before the ball speeds up; used only with PONG_SPEEDUP_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
tick  in  1  game-rate enable; state advances only on clk edges where tick=1.
serve  in  1  serve / new-game request, sampled on tick.
paddle1  in  1  player-1 paddle, at the field MSB end.
paddle2  in  1  player-2 paddle, at the field LSB end.
field  out  FIELD_W  one-hot ball position; all zeros when idle, all ones in game over.
p1_score  out  SCORE_W  player-1 points.
p2_score  out  SCORE_W  player-2 points.
p1_point  out  1  one-clk pulse when player 1 scores.
p2_point  out  1  one-clk pulse when player 2 scores.
game_over  out  1  high while in GAME_OVER.
winner  out  1  0 = player 1 won, 1 = player 2 won; valid while game_over=1.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, field=0, both scores=0, point pulses=0, game_over=0, winner=0, server=P1, speed state cleared.
- Position register pos: 0..FIELD_W-1. field = 1<<pos in RALLY. pos FIELD_W-1 is the P1 end; pos 0 is the P2 end. dir=1 means moving toward P2 (pos decrements).
- All transitions below occur only on clk edges with tick=1. With tick=0, all state and outputs hold, except point pulses, which are always cleared after one clk.
- IDLE: field=0. On serve=1:
  - pos = FIELD_W/2 (integer division).
  - dir points away from the server.
  - Go to RALLY. The ball is visible from that edge.
- RALLY, ball not at an end in its travel direction: pos steps one place in dir. Paddles and serve are ignored.
- RALLY, pos at the receiver's end (pos=0 with dir=1, or pos=FIELD_W-1 with dir=0): the receiver's paddle is sampled on this tick.
  - Hit: reverse dir and step one place away, so the ball sits at the end for exactly one tick interval.
  - Miss: opponent score += 1; opponent point pulse is high for the next clk cycle only; field=0; server becomes the player who missed.
  - After a miss, if the new score equals WIN_SCORE, go to GAME_OVER and set winner. Otherwise go to IDLE.
- GAME_OVER: field all ones, game_over=1, scores frozen. On serve: both scores=0, game_over=0, server=P1, go to IDLE. No ball is launched on this tick.
- Both paddles high simultaneously: only the receiver's paddle matters.
- Scores never exceed WIN_SCORE, so no wrap-around can occur.

Optional Feature:
PONG_SPEEDUP_EN
- Defined:
  - Each rally starts slow: the ball steps on every second tick, and end-of-field paddle checks also occur only on those step ticks.
  - After SPEEDUP_HITS successful returns in the same rally, the ball steps on every tick.
  - The hit counter and the phase bit clear on serve, on any point, and on reset.
- Undefined: the ball steps on every tick; no counter logic is present.

Test Plan:
Test parameters: FIELD_W=8, WIN_SCORE=3, macro undefined unless stated.
1. Reset, then tick+serve -> field=00010000. Next four ticks -> 00001000, 00000100, 00000010, 00000001. Tick with paddle2=0 -> field=0, p1_point high one clk, p1_score=1, next serve launches toward P1 (dir=0).
2. Ball at 00000001, tick with paddle2=1 -> 00000010, travels to 10000000. Tick with paddle1=0 -> p2_score=1, p2_point pulse.
3. Play three P1 points -> game_over=1, winner=0, field=11111111, p1_score=3. Serve tick -> scores 0/0, IDLE, field=0 with no ball.
4. tick=0 for 20 clks mid-rally with paddles toggling -> field, scores and state unchanged. Paddle high at a non-end position -> no effect.
5. Assert rst mid-rally between clk edges -> field=0, scores=0, pulses=0 immediately, without waiting for a clk edge.
6. PONG_SPEEDUP_EN, SPEEDUP_HITS=2 -> pos changes every 2 ticks until the second return, then every tick. After a point, the next rally is slow again.
